// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash read engine: opcode, frame sizes,
// FSM state encoding and the command/address frame builder.
package spi_flash_reader_pkg;

   localparam logic [7:0] CMD_READ_DEF = 8'h03;
   localparam int         SPI_BITS_TX  = 32;
   localparam int         SPI_BITS_RX  = 8;
   localparam int         SPI_BITS_ALL = SPI_BITS_TX + SPI_BITS_RX;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SEND     = 3'd2,
      ST_RECV     = 3'd3,
      ST_CS_HOLD  = 3'd4
   } state_e;

   function automatic logic [31:0] make_frame(input logic [7:0] cmd, input logic [23:0] addr);
      return {cmd, addr};
   endfunction

endpackage

// File: rtl/spi_flash_reader_sck_div.sv
// SCK half-period divider: one tick every CLK_DIV cycles while enabled,
// alternating rise/fall ticks; counter and phase are cleared while idle.
module spi_flash_reader_sck_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic rise_tick_o,
   output logic fall_tick_o
);
   localparam int            CW   = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          hi_q, hi_d;
   logic          tick_s;

   // Half-period counter and SCK phase next-state
   always_comb begin
      tick_s = en_i && (cnt_q == LAST);
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      if (!en_i) begin
         cnt_d = '0;
         hi_d  = 1'b0;
      end else if (tick_s) begin
         cnt_d = '0;
         hi_d  = ~hi_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Divider registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         hi_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
      end
   end

   assign rise_tick_o = tick_s & ~hi_q;
   assign fall_tick_o = tick_s & hi_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI-flash read engine: on a trigger edge sends READ + 24-bit address in mode 0,
// shifts back one data byte and exposes it with a busy flag for CPU polling.
module spi_flash_reader
   import spi_flash_reader_pkg::*;
#(
   parameter int         CLK_DIV  = 2,
   parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] spi_addr,
   input  logic        spi_trigger,
   output logic [7:0]  spi_data_out,
   output logic        spi_busy,
   output logic        flash_cs_n,
   output logic        flash_sck,
   output logic        flash_mosi,
   input  logic        flash_miso
);
   localparam logic [5:0] LAST_TX  = 6'(SPI_BITS_TX - 1);
   localparam logic [5:0] LAST_BIT = 6'(SPI_BITS_ALL - 1);

   state_e      state_q, state_d;
   logic        trig_q;
   logic [31:0] shift_q, shift_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  data_q, data_d;
   logic [5:0]  bit_q, bit_d;
   logic        cs_n_q, cs_n_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        busy_q, busy_d;
   logic        start_s, rise_s, fall_s, div_en_s;

   assign start_s  = spi_trigger & ~trig_q & (state_q == ST_IDLE);
   assign div_en_s = (state_q != ST_IDLE);

   spi_flash_reader_sck_div #(.CLK_DIV(CLK_DIV)) u_sck_div (
      .clk         (clk),
      .rst         (rst),
      .en_i        (div_en_s),
      .rise_tick_o (rise_s),
      .fall_tick_o (fall_s)
   );

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         trig_q  <= 1'b1;
         shift_q <= 32'h0000_0000;
         rx_q    <= 8'h00;
         data_q  <= 8'h00;
         bit_q   <= 6'd0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_q  <= spi_trigger;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         bit_q   <= bit_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; CS_HOLD is the extra high-phase half after the last bit
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start_s) state_d = ST_CS_SETUP; else state_d = ST_IDLE;
         ST_CS_SETUP: if (rise_s) state_d = ST_SEND; else state_d = ST_CS_SETUP;
         ST_SEND:     if (fall_s && bit_q == LAST_TX) state_d = ST_RECV; else state_d = ST_SEND;
         ST_RECV:     if (rise_s && bit_q == LAST_BIT) state_d = ST_CS_HOLD; else state_d = ST_RECV;
         ST_CS_HOLD:  if (fall_s) state_d = ST_IDLE; else state_d = ST_CS_HOLD;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; bit_q tracks the bit whose SCK high is current
   always_comb begin
      shift_d = shift_q;
      rx_d    = rx_q;
      data_d  = data_q;
      bit_d   = bit_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               shift_d = make_frame(CMD_READ, spi_addr);
               mosi_d  = CMD_READ[7];
               rx_d    = 8'h00;
               bit_d   = 6'd0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
            end else begin
               sck_d = 1'b0;
            end
         end
         ST_CS_SETUP: begin
            if (rise_s) sck_d = 1'b1; else sck_d = 1'b0;
         end
         ST_SEND: begin
            if (rise_s) begin
               sck_d = 1'b1;
               bit_d = bit_q + 6'd1;
            end else if (fall_s) begin
               sck_d   = 1'b0;
               shift_d = {shift_q[30:0], 1'b0};
               mosi_d  = shift_q[30];
            end else begin
               sck_d = sck_q;
            end
         end
         ST_RECV: begin
            if (rise_s && bit_q != LAST_BIT) begin
               sck_d = 1'b1;
               bit_d = bit_q + 6'd1;
               rx_d  = {rx_q[6:0], flash_miso};
            end else if (fall_s) begin
               sck_d = 1'b0;
            end else begin
               sck_d = sck_q;
            end
         end
         ST_CS_HOLD: begin
            if (fall_s) begin
               cs_n_d = 1'b1;
               busy_d = 1'b0;
               data_d = rx_q;
            end else begin
               sck_d = 1'b0;
            end
         end
         default: begin
            cs_n_d = 1'b1;
            sck_d  = 1'b0;
            busy_d = 1'b0;
         end
      endcase
   end

   assign spi_data_out = data_q;
   assign spi_busy     = busy_q;
   assign flash_cs_n   = cs_n_q;
   assign flash_sck    = sck_q;
   assign flash_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench: two engines (CLK_DIV=2 and CLK_DIV=1), each with a mode-0 flash model.
module tb_spi_flash_reader;
   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic [1:0]  trig = 2'b11;
   logic [23:0] addr [2];
   logic [7:0]  resp [2];
   logic [1:0]  busy_all;
   int          cyc   = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   always @(negedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 2 : 1;
      logic        cs_n, sck, mosi, busy;
      logic        miso = 1'b0;
      logic [7:0]  dout;
      logic        sck_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0;
      int          rises = 0, falls = 0, busy_cnt = 0, cs_falls = 0;
      int          viol = 0, bad_per = 0, mosi_rx = 0, last_rise = 0;
      logic [31:0] cap = 32'd0;
      logic [7:0]  tx  = 8'd0;

      spi_flash_reader #(.CLK_DIV(DIV)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .spi_addr     (addr[g]),
         .spi_trigger  (trig[g]),
         .spi_data_out (dout),
         .spi_busy     (busy),
         .flash_cs_n   (cs_n),
         .flash_sck    (sck),
         .flash_mosi   (mosi),
         .flash_miso   (miso)
      );

      assign busy_all[g] = busy;

      // Flash model and bus monitor, sampled away from the active edge
      always @(negedge clk) begin
         sck_p  <= sck;
         cs_p   <= cs_n;
         busy_p <= busy;
         if (sck && cs_n) viol <= viol + 1;
         if (busy && !busy_p) busy_cnt <= 1;
         else if (busy) busy_cnt <= busy_cnt + 1;
         if (cs_p && !cs_n) begin
            cs_falls <= cs_falls + 1;
            rises    <= 0;
            falls    <= 0;
            cap      <= 32'd0;
            mosi_rx  <= 0;
            tx       <= resp[g];
         end else if (!cs_n) begin
            if (sck && !sck_p) begin
               rises <= rises + 1;
               if (rises < 32) cap <= {cap[30:0], mosi};
               else if (mosi) mosi_rx <= mosi_rx + 1;
               if (rises > 0 && (cyc - last_rise) != 2 * DIV) bad_per <= bad_per + 1;
               last_rise <= cyc;
            end
            if (!sck && sck_p) begin
               falls <= falls + 1;
               if (falls >= 31 && falls <= 38) begin
                  miso <= tx[7];
                  tx   <= {tx[6:0], 1'b0};
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input logic idx, input string tag);
      int n;
      n = 0;
      while (busy_all[idx] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_end_timeout"}, 32'(busy_all[idx]), 32'd0);
   endtask

   task automatic run_txn(input logic idx, input logic [23:0] a, input logic [7:0] r, input string tag);
      addr[idx] = a;
      resp[idx] = r;
      trig[idx] = 1'b1;
      @(negedge clk);
      chk({tag, "_busy_rise"}, 32'(busy_all[idx]), 32'd1);
      wait_idle(idx, tag);
   endtask

   initial begin
      int n;
      int base;
      addr[0] = 24'h000000;
      addr[1] = 24'h000000;
      resp[0] = 8'h00;
      resp[1] = 8'h00;

      // Reset with trigger held high on both engines
      repeat (3) @(negedge clk);
      chk("t1_cs_n", 32'(g_dut[0].cs_n), 32'd1);
      chk("t1_sck", 32'(g_dut[0].sck), 32'd0);
      chk("t1_mosi", 32'(g_dut[0].mosi), 32'd0);
      chk("t1_busy", 32'(g_dut[0].busy), 32'd0);
      chk("t1_dout", 32'(g_dut[0].dout), 32'd0);
      chk("t1_cs_n_div1", 32'(g_dut[1].cs_n), 32'd1);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("t1_no_start_busy", 32'(g_dut[0].busy), 32'd0);
      chk("t1_no_start_cs", 32'(g_dut[0].cs_falls), 32'd0);
      chk("t1_no_start_cs_div1", 32'(g_dut[1].cs_falls), 32'd0);
      trig = 2'b00;
      @(negedge clk);

      // Basic read
      run_txn(1'b0, 24'h123456, 8'hA5, "t2");
      chk("t2_mosi", g_dut[0].cap, 32'h0312_3456);
      chk("t2_rises", 32'(g_dut[0].rises), 32'd40);
      chk("t2_busy_len", 32'(g_dut[0].busy_cnt), 32'd164);
      chk("t2_dout", 32'(g_dut[0].dout), 32'h0000_00A5);
      chk("t2_cs_falls", 32'(g_dut[0].cs_falls), 32'd1);

      // Trigger still high: no retrigger; then a fresh edge at the top address
      base = g_dut[0].cs_falls;
      repeat (20) @(negedge clk);
      chk("t3_no_retrig_cs", 32'(g_dut[0].cs_falls), 32'(base));
      chk("t3_no_retrig_busy", 32'(g_dut[0].busy), 32'd0);
      trig[0] = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 24'hFFFFFF, 8'h5A, "t3");
      chk("t3_mosi", g_dut[0].cap, 32'h03FF_FFFF);
      chk("t3_dout", 32'(g_dut[0].dout), 32'h0000_005A);
      chk("t3_busy_len", 32'(g_dut[0].busy_cnt), 32'd164);

      // Trigger pulse and address change while busy
      trig[0] = 1'b0;
      @(negedge clk);
      base = g_dut[0].cs_falls;
      addr[0] = 24'hC0FFEE;
      resp[0] = 8'h96;
      trig[0] = 1'b1;
      @(negedge clk);
      chk("t4_busy_rise", 32'(g_dut[0].busy), 32'd1);
      repeat (20) @(negedge clk);
      addr[0] = 24'h000000;
      trig[0] = 1'b0;
      @(negedge clk);
      trig[0] = 1'b1;
      @(negedge clk);
      trig[0] = 1'b0;
      chk("t4_dout_stable", 32'(g_dut[0].dout), 32'h0000_005A);
      wait_idle(1'b0, "t4");
      chk("t4_mosi", g_dut[0].cap, 32'h03C0_FFEE);
      chk("t4_dout", 32'(g_dut[0].dout), 32'h0000_0096);
      repeat (10) @(negedge clk);
      chk("t4_single_txn", 32'(g_dut[0].cs_falls), 32'(base + 1));

      // Reset during the data phase, then a normal read
      addr[0] = 24'h000001;
      resp[0] = 8'hFF;
      trig[0] = 1'b1;
      @(negedge clk);
      n = 0;
      while (g_dut[0].rises < 35 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_recv", 32'(g_dut[0].rises >= 35), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_cs_n", 32'(g_dut[0].cs_n), 32'd1);
      chk("t5_rst_sck", 32'(g_dut[0].sck), 32'd0);
      chk("t5_rst_busy", 32'(g_dut[0].busy), 32'd0);
      chk("t5_rst_dout", 32'(g_dut[0].dout), 32'd0);
      rst = 1'b0;
      trig[0] = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 24'h5A5A5A, 8'h81, "t5");
      chk("t5_mosi", g_dut[0].cap, 32'h035A_5A5A);
      chk("t5_dout", 32'(g_dut[0].dout), 32'h0000_0081);
      chk("t5_busy_len", 32'(g_dut[0].busy_cnt), 32'd164);
      chk("t5_rises", 32'(g_dut[0].rises), 32'd40);
      trig[0] = 1'b0;

      // CLK_DIV=1 engine
      run_txn(1'b1, 24'h000010, 8'h3C, "t6");
      chk("t6_mosi", g_dut[1].cap, 32'h0300_0010);
      chk("t6_busy_len", 32'(g_dut[1].busy_cnt), 32'd82);
      chk("t6_rises", 32'(g_dut[1].rises), 32'd40);
      chk("t6_dout", 32'(g_dut[1].dout), 32'h0000_003C);
      chk("t6_sck_period", 32'(g_dut[1].bad_per), 32'd0);
      trig[1] = 1'b0;
      repeat (5) @(negedge clk);

      chk("all_sck_period_div2", 32'(g_dut[0].bad_per), 32'd0);
      chk("all_sck_with_cs_high_div2", 32'(g_dut[0].viol), 32'd0);
      chk("all_sck_with_cs_high_div1", 32'(g_dut[1].viol), 32'd0);
      chk("all_mosi_in_recv_div2", 32'(g_dut[0].mosi_rx), 32'd0);
      chk("all_mosi_in_recv_div1", 32'(g_dut[1].mosi_rx), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
